rgb_fade_pwm: RTL and testbench
===============================

# rgb_fade_pwm

Downstream stage of the RGB LED sequencer: takes its three on/off channel commands and drives the physical LED pins with PWM. Each channel ramps its brightness linearly toward full-on or full-off, so step changes in the command become visible fades. All logic runs on one clock. Outputs connect directly to the board's RGB LED pins.

## Interface

- PWM_BITS, 8: width of the PWM counter and brightness levels.
- MAX_LEVEL, 255: brightness reached when a command is high. Must be ≤ 2^PWM_BITS−1.
- STEP_DIV, 10000: clock cycles per brightness step. Must be ≥ 1.

Ports:

- clk  in  1  system clock. Single clock; all flops are on its rising edge.
- rst_n  in  1  reset. Asynchronous assert, active-low.
- red_in  in  1  red command from the sequencer. Same clock domain.
- green_in  in  1  green command from the sequencer.
- blue_in  in  1  blue command from the sequencer.
- pwm_r  out  1  red LED drive, registered.
- pwm_g  out  1  green LED drive, registered.
- pwm_b  out  1  blue LED drive, registered.
- fading  out  3  per-channel ramp-in-progress flags, ordered {b,g,r}.
- settled  out  1  high when all three levels equal their targets.

## Operation

- **Input register:** each command is registered once into `in_q`. The channel target is MAX_LEVEL when `in_q` is 1, and 0 otherwise.
- **Prescaler:**
  - Counts 0..STEP_DIV−1, then wraps to 0.
  - `tick` is high for one cycle when the prescaler equals STEP_DIV−1.
  - With STEP_DIV=1, `tick` is high every cycle.
- **PWM counter:**
  - Counts 0..2^PWM_BITS−2, then wraps to 0.
  - Period is 2^PWM_BITS−1 cycles.
  - The counter is free-running and shared by all three channels.
- **Per-channel level register** (PWM_BITS wide). On `tick`:
  - level < target: level+1.
  - level > target: level−1.
  - Equal: hold.
  - No overflow or underflow is possible; the level stays within [0, MAX_LEVEL].
- **Per-channel state machine** (derived from level and target):
  - States: OFF (level=0, target=0), RISING (level<target), ON (level=MAX_LEVEL, target=MAX_LEVEL), FALLING (level>target).
  - OFF→RISING when `in_q` rises.
  - RISING→ON on the tick that reaches MAX_LEVEL.
  - ON→FALLING when `in_q` falls.
  - FALLING→OFF on the tick that reaches 0.
  - RISING↔FALLING directly when the command reverses mid-ramp. Direction changes on the next tick; the level never jumps.
- **Outputs:**
  - pwm_x <= (level_x > pwm_cnt). Level 0 gives constant 0. Level 2^PWM_BITS−1 gives constant 1. Level L gives L high cycles per period.
  - fading[x] = (level_x ≠ target_x).
  - settled = ~|fading.
- **Reset (rst_n low):** takes effect immediately and asynchronously.
  - Cleared to 0: `in_q`, prescaler, PWM counter, all levels, pwm_r/g/b, fading.
  - settled = 1.
  - Reset mid-fade discards the ramp. After release, ramps restart from 0 toward the current commands.

## Timing

- A command edge at cycle n is in `in_q` at n+1. `fading` rises at n+1.
- The first level change occurs on the first `tick` at or after n+2.
- A full ramp takes MAX_LEVEL ticks, i.e. MAX_LEVEL×STEP_DIV cycles ±STEP_DIV.
- The PWM output lags the level and counter by one cycle (registered compare).
- Simultaneous events:
  - Command changes on three channels in the same cycle all step on the same tick.
  - A command change on the same cycle as `tick` steps using the old target; the new target applies from the next tick.
- A command pulse shorter than one cycle is not supported. Any pulse of ≥1 cycle is captured.
- After release of rst_n, the prescaler starts at 0, so the first tick occurs STEP_DIV cycles after release.

## Test plan

All scenarios use PWM_BITS=4, MAX_LEVEL=15, STEP_DIV=2 unless stated.

1. **Reset values:** hold rst_n low with random commands → pwm_r/g/b=0, fading=0, settled=1. Assert rst_n asynchronously between clock edges → outputs clear without waiting for a clock edge.
2. **Rise to full-on:** red_in=1 from cycle 0 → level_r steps +1 every 2 cycles and reaches 15 within 30–32 cycles. At level 5, pwm_r is high exactly 5 of 15 cycles. At level 15, pwm_r stays constantly high. fading[0] then drops and settled rises.
3. **Mid-ramp reversal:** drop red_in when level_r=7 → level_r goes 6,5,…,0 over 7 ticks with no jump. At 0, pwm_r stays constant 0 and the channel returns to OFF.
4. **Simultaneous channels:** all commands rise in one cycle → the three levels match on every cycle, and pwm_r=pwm_g=pwm_b throughout.
5. **STEP_DIV=1 and MAX_LEVEL=10 boundary:** the level reaches 10 in 10–11 cycles and never exceeds 10. pwm_g duty is 10/15.
6. **Reset mid-fade:** pulse rst_n low at level 9 with blue_in=1 held → after release, level_b restarts at 0. The first step occurs 2 cycles after release, and the level reaches 15 again.

Source files
------------

// File: rtl/rgb_fade_pwm.sv
// rtl/rgb_fade_pwm.sv - three-channel RGB LED driver with linear brightness fades and PWM output

// One colour channel: command capture, level ramp, ramp-state tracking and PWM compare.
module rgb_fade_channel #(
  parameter int PWM_BITS  = 8,
  parameter int MAX_LEVEL = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd,
  input  logic                tick,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                pwm,
  output logic                fading
);

  localparam logic [PWM_BITS-1:0] FULL = PWM_BITS'(MAX_LEVEL);
  localparam logic [PWM_BITS-1:0] ONE  = PWM_BITS'(1);

  typedef enum logic [1:0] {
    OFF     = 2'd0,
    RISING  = 2'd1,
    ON      = 2'd2,
    FALLING = 2'd3
  } state_t;

  state_t              state;
  logic                in_q;
  logic [PWM_BITS-1:0] level;
  logic [PWM_BITS-1:0] level_nxt;
  logic [PWM_BITS-1:0] target;
  logic [PWM_BITS-1:0] target_nxt;

  // The target seen by the ramp is always the registered command; target_nxt
  // is what the target becomes after this edge, used to keep the state current.
  assign target     = in_q ? FULL : '0;
  assign target_nxt = cmd  ? FULL : '0;

  // Move one step toward the target on each prescaler tick, never past it.
  always_comb begin
    level_nxt = level;
    if (tick) begin
      if (level < target) begin
        level_nxt = level + ONE;
      end else if (level > target) begin
        level_nxt = level - ONE;
      end
    end
  end

  // Command capture, level register and registered PWM compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q  <= 1'b0;
      level <= '0;
      pwm   <= 1'b0;
    end else begin
      in_q  <= cmd;
      level <= level_nxt;
      pwm   <= (level > pwm_cnt);
    end
  end

  // Ramp state: classifies the post-edge level against the post-edge target so
  // that a reversal mid-ramp switches RISING/FALLING directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= OFF;
    end else begin
      if (level_nxt == target_nxt) begin
        state <= cmd ? ON : OFF;
      end else if (level_nxt < target_nxt) begin
        state <= RISING;
      end else begin
        state <= FALLING;
      end
    end
  end

  assign fading = (state == RISING) || (state == FALLING);

endmodule

// Top level: shared prescaler and PWM counter feeding three channels.
module rgb_fade_pwm #(
  parameter int PWM_BITS  = 8,
  parameter int MAX_LEVEL = 255,
  parameter int STEP_DIV  = 10000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       red_in,
  input  logic       green_in,
  input  logic       blue_in,
  output logic       pwm_r,
  output logic       pwm_g,
  output logic       pwm_b,
  output logic [2:0] fading,
  output logic       settled
);

  localparam int                  PRE_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(STEP_DIV - 1);
  localparam logic [PRE_W-1:0]    PRE_ONE  = PRE_W'(1);
  localparam logic [PWM_BITS-1:0] CNT_LAST = PWM_BITS'((1 << PWM_BITS) - 2);
  localparam logic [PWM_BITS-1:0] CNT_ONE  = PWM_BITS'(1);

  logic [PRE_W-1:0]    presc;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                tick;
  logic [2:0]          cmd;
  logic [2:0]          pwm_v;

  assign tick = (presc == PRE_LAST);
  assign cmd  = {blue_in, green_in, red_in};

  // Step-rate prescaler, wraps after STEP_DIV cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + PRE_ONE;
    end
  end

  // Free-running PWM counter; stopping one short of all-ones lets full level mean always-on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
    end else if (pwm_cnt == CNT_LAST) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + CNT_ONE;
    end
  end

  for (genvar ch = 0; ch < 3; ch++) begin : g_ch
    rgb_fade_channel #(
      .PWM_BITS (PWM_BITS),
      .MAX_LEVEL(MAX_LEVEL)
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .cmd    (cmd[ch]),
      .tick   (tick),
      .pwm_cnt(pwm_cnt),
      .pwm    (pwm_v[ch]),
      .fading (fading[ch])
    );
  end

  assign pwm_r   = pwm_v[0];
  assign pwm_g   = pwm_v[1];
  assign pwm_b   = pwm_v[2];
  assign settled = ~|fading;

endmodule

// File: tb/tb_rgb_fade_pwm.sv
// tb/tb_rgb_fade_pwm.sv - randomized and directed checks of rgb_fade_pwm against a behavioural model
module tb_rgb_fade_pwm;

  localparam int PERIOD = 15;

  logic       clk = 1'b0;
  logic       rst_a;
  logic       rst_b;
  logic [2:0] cmd_a;
  logic [2:0] cmd_b;
  logic       pr_a, pg_a, pb_a, st_a;
  logic       pr_b, pg_b, pb_b, st_b;
  logic [2:0] fd_a, fd_b;

  int checks = 0;
  int errors = 0;

  int m_inq [2][3];
  int m_lvl [2][3];
  int m_pwm [2][3];
  int m_cyc [2];

  always #5 clk = ~clk;

  rgb_fade_pwm #(.PWM_BITS(4), .MAX_LEVEL(15), .STEP_DIV(2)) dut_a (
    .clk(clk), .rst_n(rst_a),
    .red_in(cmd_a[0]), .green_in(cmd_a[1]), .blue_in(cmd_a[2]),
    .pwm_r(pr_a), .pwm_g(pg_a), .pwm_b(pb_a),
    .fading(fd_a), .settled(st_a)
  );

  rgb_fade_pwm #(.PWM_BITS(4), .MAX_LEVEL(10), .STEP_DIV(1)) dut_b (
    .clk(clk), .rst_n(rst_b),
    .red_in(cmd_b[0]), .green_in(cmd_b[1]), .blue_in(cmd_b[2]),
    .pwm_r(pr_b), .pwm_g(pg_b), .pwm_b(pb_b),
    .fading(fd_b), .settled(st_b)
  );

  task automatic check_val(input string tag, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, want, $time);
    end
  endtask

  function automatic int step_div(input int k);
    return (k == 0) ? 2 : 1;
  endfunction

  function automatic int max_lvl(input int k);
    return (k == 0) ? 15 : 10;
  endfunction

  function automatic int tgt(input int k, input int ch);
    return (m_inq[k][ch] != 0) ? max_lvl(k) : 0;
  endfunction

  task automatic model_reset(input int k);
    for (int ch = 0; ch < 3; ch++) begin
      m_inq[k][ch] = 0;
      m_lvl[k][ch] = 0;
      m_pwm[k][ch] = 0;
    end
    m_cyc[k] = 0;
  endtask

  // One active edge: counters are simple functions of cycles since reset release.
  task automatic model_step(input int k, input logic [2:0] cmd);
    int  cnt;
    bit  tick;
    cnt  = m_cyc[k] % PERIOD;
    tick = (m_cyc[k] % step_div(k)) == step_div(k) - 1;
    for (int ch = 0; ch < 3; ch++) begin
      m_pwm[k][ch] = (m_lvl[k][ch] > cnt) ? 1 : 0;
      if (tick) begin
        if (m_lvl[k][ch] < tgt(k, ch)) m_lvl[k][ch]++;
        else if (m_lvl[k][ch] > tgt(k, ch)) m_lvl[k][ch]--;
      end
      m_inq[k][ch] = cmd[ch] ? 1 : 0;
    end
    m_cyc[k]++;
  endtask

  function automatic int want_pwm(input int k);
    return m_pwm[k][0] + 2 * m_pwm[k][1] + 4 * m_pwm[k][2];
  endfunction

  function automatic int want_fading(input int k);
    int f = 0;
    for (int ch = 0; ch < 3; ch++)
      if (m_lvl[k][ch] != tgt(k, ch)) f += (1 << ch);
    return f;
  endfunction

  task automatic compare_all();
    check_val("a_pwm", int'({pb_a, pg_a, pr_a}), want_pwm(0));
    check_val("a_fading", int'(fd_a), want_fading(0));
    check_val("a_settled", int'(st_a), (want_fading(0) == 0) ? 1 : 0);
    check_val("b_pwm", int'({pb_b, pg_b, pr_b}), want_pwm(1));
    check_val("b_fading", int'(fd_b), want_fading(1));
    check_val("b_settled", int'(st_b), (want_fading(1) == 0) ? 1 : 0);
  endtask

  task automatic run_cycle();
    @(posedge clk);
    if (rst_a) model_step(0, cmd_a); else model_reset(0);
    if (rst_b) model_step(1, cmd_b); else model_reset(1);
    @(negedge clk);
    compare_all();
  endtask

  task automatic wait_settled(input int k, input int limit, output int n);
    n = 0;
    do begin
      run_cycle();
      n++;
    end while (((k == 0) ? st_a : st_b) == 1'b0 && n < limit);
    check_val("settle_timeout", int'((k == 0) ? st_a : st_b), 1);
  endtask

  task automatic wait_level(input int k, input int ch, input int lvl);
    int n = 0;
    while (m_lvl[k][ch] != lvl && n < 60) begin
      run_cycle();
      n++;
    end
    check_val("level_timeout", (n < 60) ? 1 : 0, 1);
  endtask

  initial begin
    int n;
    int high;
    rst_a = 1'b0;
    rst_b = 1'b0;
    cmd_a = 3'($urandom);
    cmd_b = 3'($urandom);
    model_reset(0);
    model_reset(1);

    // Reset values with random commands applied.
    repeat (3) run_cycle();
    check_val("rst_pwm", int'({pb_a, pg_a, pr_a}), 0);
    check_val("rst_settled", int'(st_a), 1);

    // Rise to full-on from release.
    cmd_a = 3'b001;
    rst_a = 1'b1;
    wait_settled(0, 60, n);
    check_val("rise_len_in_30_32", (n >= 30 && n <= 32) ? 1 : 0, 1);
    high = 0;
    repeat (PERIOD) begin run_cycle(); high += int'(pr_a); end
    check_val("full_duty", high, 15);

    // Fall, then reverse mid-ramp at level 7.
    cmd_a = 3'b000;
    wait_settled(0, 60, n);
    cmd_a = 3'b001;
    wait_level(0, 0, 7);
    cmd_a = 3'b000;
    wait_settled(0, 60, n);
    check_val("reverse_len", (n >= 14 && n <= 16) ? 1 : 0, 1);
    high = 0;
    repeat (PERIOD) begin run_cycle(); high += int'(pr_a); end
    check_val("off_duty", high, 0);

    // All three channels rise together.
    cmd_a = 3'b111;
    repeat (40) begin
      run_cycle();
      check_val("sim_equal", (pr_a == pg_a && pg_a == pb_a) ? 1 : 0, 1);
    end
    check_val("sim_settled", int'(st_a), 1);

    // STEP_DIV=1, MAX_LEVEL=10 boundary.
    cmd_b = 3'b010;
    rst_b = 1'b1;
    wait_settled(1, 30, n);
    check_val("b_rise_len_in_10_11", (n >= 10 && n <= 11) ? 1 : 0, 1);
    high = 0;
    repeat (PERIOD) begin run_cycle(); high += int'(pg_b); end
    check_val("b_duty", high, 10);

    // Reset mid-fade on blue at level 9, asserted between clock edges.
    cmd_a = 3'b000;
    wait_settled(0, 60, n);
    cmd_a = 3'b100;
    wait_level(0, 2, 9);
    #2 rst_a = 1'b0;
    #1;
    check_val("async_pwm", int'({pb_a, pg_a, pr_a}), 0);
    check_val("async_fading", int'(fd_a), 0);
    check_val("async_settled", int'(st_a), 1);
    model_reset(0);
    repeat (2) run_cycle();
    rst_a = 1'b1;
    wait_settled(0, 60, n);
    check_val("restart_len_in_30_32", (n >= 30 && n <= 32) ? 1 : 0, 1);

    // Randomized commands with random hold times and occasional reset pulses.
    repeat (40) begin
      cmd_a = 3'($urandom);
      cmd_b = 3'($urandom);
      if ($urandom_range(0, 7) == 0) rst_a = 1'b0;
      if ($urandom_range(0, 7) == 0) rst_b = 1'b0;
      run_cycle();
      rst_a = 1'b1;
      rst_b = 1'b1;
      repeat ($urandom_range(1, 40)) run_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
